rom_match_sched: RTL and testbench

- Round-robin scheduler that shares one 8-entry pattern ROM and its match-accumulate datapath among N requesters.
- Each requester submits an 8-bit input word. The block captures the winner's word, steps the ROM address 0..7, and ORs the 4-bit code of every matching entry into an accumulator.
- It then returns the 4-bit result tagged with the requester index.
- Sits between the requester ports and an external ROM, and owns ROM addressing.

---
 rtl/rom_match_sched.sv | 93 +++++++++
 tb/tb_rom_match_sched.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rom_match_sched.sv
// rom_match_sched: round-robin share of one 8-entry pattern ROM and its match-accumulate datapath.
// Define ROM_MATCH_EARLY_EXIT_EN to leave the scan as soon as the accumulator saturates at 4'hF.
module rom_match_sched #(
    parameter int N   = 2,
    parameter int IDW = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [N-1:0]     REQ,
    input  logic [8*N-1:0]   DIN,
    output logic [N-1:0]     GNT,
    output logic [2:0]       ROM_ADDR,
    input  logic [19:0]      ROM_DATA,
    output logic [3:0]       O,
    output logic             DONE,
    output logic [IDW-1:0]   DONE_ID,
    output logic             BUSY
);
    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
    state_t state, state_nxt;
    logic [7:0]     in_r;
    logic [3:0]     out_r, acc;
    logic [IDW-1:0] ptr, cur, win, ptr_nxt;
    logic           found, match, last;
    int             idx;
    // First requester at or above ptr, wrapping around
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        ptr_nxt = IDW'((int'(win) + 1) % N);
    end
    always_comb begin
        match = ((ROM_DATA[11:4] & ~in_r) | (ROM_DATA[19:12] & in_r) | (ROM_DATA[11:4] & ROM_DATA[19:12])) == 8'hFF;
        acc   = out_r | (match ? ROM_DATA[3:0] : 4'h0);
`ifdef ROM_MATCH_EARLY_EXIT_EN
        last  = (ROM_ADDR == 3'd7) || (acc == 4'hF);
`else
        last  = ROM_ADDR == 3'd7;
`endif
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE)      state_nxt = found ? SCAN : IDLE;
        else if (state == SCAN) state_nxt = last ? FIN : SCAN;
        else                    state_nxt = IDLE;
    end
    always_comb begin
        GNT  = (state == IDLE && found) ? (N'(1) << win) : '0;
        DONE = state == FIN;
        BUSY = state != IDLE;
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ROM_ADDR <= '0;
            in_r     <= '0;
            out_r    <= '0;
            O        <= '0;
            DONE_ID  <= '0;
            cur      <= '0;
            ptr      <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                in_r     <= DIN[8*int'(win) +: 8];
                out_r    <= '0;
                ROM_ADDR <= '0;
                cur      <= win;
                ptr      <= ptr_nxt;
            end
        end else if (state == SCAN) begin
            out_r <= acc;
            if (last) begin
                O       <= acc;
                DONE_ID <= cur;
            end else begin
                ROM_ADDR <= ROM_ADDR + 3'd1;
            end
        end else begin
            ROM_ADDR <= '0;
        end
    end
endmodule

// File: tb/tb_rom_match_sched.sv
// tb_rom_match_sched: table-driven jobs against a ROM model, results checked through a scoreboard queue.
module tb_rom_match_sched;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  REQ = '0;
    logic [15:0] DIN = '0;
    logic [1:0]  GNT;
    logic [2:0]  ROM_ADDR;
    logic [19:0] ROM_DATA;
    logic [3:0]  O;
    logic        DONE;
    logic [0:0]  DONE_ID;
    logic        BUSY;
    int          rom_mode = 0;
    int          checks = 0;
    int          failures = 0;
`ifdef ROM_MATCH_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    typedef struct {logic [3:0] o; logic [0:0] id;} res_t;
    res_t sb[$];
    typedef struct {int mode; logic [1:0] req; logic [15:0] din; logic [3:0] eo; int id;} vec_t;
    vec_t vecs[8];

    rom_match_sched #(.N(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .DIN(DIN), .GNT(GNT),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .O(O), .DONE(DONE),
        .DONE_ID(DONE_ID), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // Mode 0: everything matches, code 1. Mode 1: R1=F0,R2=0F, one-hot code by address. Mode 2: match, code 0.
    always_comb
        ROM_DATA = rom_mode == 0 ? {8'hFF, 8'hFF, 4'h1} :
                   rom_mode == 1 ? {8'hF0, 8'h0F, 4'b0001 << ROM_ADDR[1:0]} :
                                   {8'hFF, 8'hFF, 4'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (!RESET && DONE) begin
            if (sb.size() == 0) chk("unexpected_done", 32'(DONE), 32'd0);
            else begin
                res_t r;
                r = sb.pop_front();
                chk("result_o", 32'(O), 32'(r.o));
                chk("result_id", 32'(DONE_ID), 32'(r.id));
            end
        end
    end

    task automatic run_job(input int mode, input logic [1:0] req, input logic [15:0] din,
                           input logic [3:0] eo, input int id, input bit flip, input bit abort);
        int lat;
        res_t r;
        lat = (EE && eo == 4'hF) ? 5 : 9;
        @(negedge CLOCK);
        rom_mode = mode;
        REQ = req;
        DIN = din;
        #1;
        chk("grant", 32'(GNT), 32'(2'b01 << id));
        r.o = eo;
        r.id = 1'(id);
        if (!abort) sb.push_back(r);
        for (int c = 1; c <= lat; c++) begin
            @(negedge CLOCK);
            if (flip && c == 2) DIN[7:0] = ~DIN[7:0];
            if (abort && c == 4) begin
                RESET = 1'b1;
                REQ = '0;
                @(negedge CLOCK);
                RESET = 1'b0;
                chk("abort_o", 32'(O), 32'd0);
                chk("abort_id", 32'(DONE_ID), 32'd0);
                chk("abort_busy", 32'(BUSY), 32'd0);
                chk("abort_addr", 32'(ROM_ADDR), 32'd0);
                repeat (12) @(negedge CLOCK);
                chk("abort_idle", 32'({BUSY, DONE}), 32'd0);
                return;
            end
            chk("no_grant_busy", 32'(GNT), 32'd0);
            chk("busy", 32'(BUSY), 32'd1);
            if (c < lat) begin
                chk("rom_addr", 32'(ROM_ADDR), 32'(c - 1));
                chk("done_early", 32'(DONE), 32'd0);
            end else begin
                chk("done_pulse", 32'(DONE), 32'd1);
            end
        end
        REQ = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 2'b01, 16'h005A, 4'h1, 0};
        vecs[1] = '{2, 2'b01, 16'h0000, 4'h0, 0};
        vecs[2] = '{1, 2'b10, 16'hF000, 4'hF, 1};
        vecs[3] = '{1, 2'b01, 16'h000F, 4'h0, 0};
        vecs[4] = '{1, 2'b11, 16'h0FF0, 4'h0, 1};
        vecs[5] = '{1, 2'b11, 16'h0FF0, 4'hF, 0};
        vecs[6] = '{1, 2'b11, 16'h0FF0, 4'h0, 1};
        vecs[7] = '{1, 2'b11, 16'h0FF0, 4'hF, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK);
            if (i == 2) RESET = 1'b0;
            chk("reset_state", 32'({O, DONE, GNT, BUSY, ROM_ADDR}), 32'd0);
        end
        // 0..3 single jobs incl. pointer wrap; 4..7 back-to-back fairness with both requesting
        for (int i = 0; i < 8; i++)
            run_job(vecs[i].mode, vecs[i].req, vecs[i].din, vecs[i].eo, vecs[i].id, 1'b0, 1'b0);
        @(negedge CLOCK);
        chk("fin_to_idle", 32'({BUSY, DONE}), 32'd0);
        chk("o_hold", 32'(O), 32'hF);
        run_job(1, 2'b01, 16'h00F0, 4'hF, 0, 1'b1, 1'b0);
        run_job(1, 2'b11, 16'h00F0, 4'hF, 1, 1'b0, 1'b1);
        run_job(1, 2'b11, 16'hF000, 4'h0, 0, 1'b0, 1'b0);
        run_job(0, 2'b10, 16'h0000, 4'h1, 1, 1'b0, 1'b0);
        repeat (3) @(negedge CLOCK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
